move_sched: RTL and testbench

MOVE_SCHED -- requirements
Module: move_sched

---
 rtl/move_sched_pkg.sv | 52 +++++
 rtl/move_sched_grav_timer.sv | 51 +++++
 rtl/move_sched.sv | 142 ++++++++++++++
 tb/tb_move_sched.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/move_sched_pkg.sv
// rtl/move_sched_pkg.sv - shared encodings and helpers for the move scheduler
//
// Purpose : move_op codes, scheduler state encoding, watchdog limit, key bit
//           positions and the fixed-priority op selection helpers.
// Ports   : none (package).
package move_sched_pkg;

   typedef enum logic [2:0] {
      OP_NONE      = 3'd0,
      OP_ROTATE    = 3'd1,
      OP_SOFT_DOWN = 3'd2,
      OP_LEFT      = 3'd3,
      OP_RIGHT     = 3'd4,
      OP_GRAVITY   = 3'd5,
      OP_LOCK      = 3'd6
   } move_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_LOCK = 2'd2
   } state_e;

   localparam logic [7:0] WD_LIMIT = 8'd255;

   localparam int KEY_UP    = 0;
   localparam int KEY_DOWN  = 1;
   localparam int KEY_LEFT  = 2;
   localparam int KEY_RIGHT = 3;

   // Fixed priority: GRAVITY > ROTATE > LEFT > RIGHT > SOFT_DOWN.
   function automatic move_op_e pick_op(input logic grav, input logic [3:0] pend);
      if (grav)                 return OP_GRAVITY;
      else if (pend[KEY_UP])    return OP_ROTATE;
      else if (pend[KEY_LEFT])  return OP_LEFT;
      else if (pend[KEY_RIGHT]) return OP_RIGHT;
      else if (pend[KEY_DOWN])  return OP_SOFT_DOWN;
      else                      return OP_NONE;
   endfunction

   // Pending-register bit that a granted op consumes.
   function automatic logic [3:0] op_key_mask(input move_op_e op);
      case (op)
         OP_ROTATE:    return 4'b0001;
         OP_SOFT_DOWN: return 4'b0010;
         OP_LEFT:      return 4'b0100;
         OP_RIGHT:     return 4'b1000;
         default:      return 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/move_sched_grav_timer.sv
// rtl/move_sched_grav_timer.sv - frame counter producing the gravity-due flag
//
// Purpose : counts draw_finish pulses; the MOVE_DELAY-th pulse raises
//           gravity-due and restarts the count. The count holds while a
//           gravity step is already due so steps never accumulate.
// Ports   : clk, rst_n      - clock, asynchronous active-low reset
//           draw_finish     - end-of-frame pulse
//           clr_cnt         - restart the frame count (soft drop applied)
//           clr_due         - gravity step granted this cycle
//           grav_due        - gravity step due, including one reached this cycle
module grav_timer #(
   parameter int MOVE_DELAY = 30
) (
   input  logic clk,
   input  logic rst_n,
   input  logic draw_finish,
   input  logic clr_cnt,
   input  logic clr_due,
   output logic grav_due
);

   localparam logic [7:0] CNT_LAST = 8'(MOVE_DELAY - 1);

   logic [7:0] cnt_q, cnt_d;
   logic       due_q, due_d;
   logic       hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 8'd0;
         due_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         due_q <= due_d;
      end
   end

   always_comb begin
      hit   = draw_finish && !due_q && (cnt_q == CNT_LAST);
      cnt_d = cnt_q;
      if (clr_cnt)
         cnt_d = 8'd0;
      else if (draw_finish && !due_q)
         cnt_d = hit ? 8'd0 : cnt_q + 8'd1;
      // The frame that reaches the delay is visible to the scheduler at once,
      // so an idle scheduler grants gravity on that very draw_finish.
      grav_due = due_q || hit;
      due_d    = grav_due && !clr_due;
   end

endmodule

// File: rtl/move_sched.sv
// rtl/move_sched.sv - key/gravity move scheduler with grid-controller handshake
//
// Purpose : collects key pulses and gravity ticks, grants at most one move per
//           frame by fixed priority, and runs a req/ack handshake with the grid
//           controller; a blocked gravity step is followed by a LOCK request.
//           Optional watchdog: define MOVE_SCHED_TIMEOUT_EN.
// Ports   : vga_clk, i_reset_n  - clock, asynchronous active-low reset
//           op_keys[3:0]        - key pulses: up/rotate, down, left, right
//           draw_finish         - end-of-frame pulse
//           move_req, move_op   - request and operation code to grid controller
//           move_ack, move_ok   - completion pulse and applied/blocked status
//           sched_err           - handshake-timeout pulse
module move_sched
   import move_sched_pkg::*;
#(
   parameter int MOVE_DELAY = 30
) (
   input  logic       vga_clk,
   input  logic       i_reset_n,
   input  logic [3:0] op_keys,
   input  logic       draw_finish,
   output logic       move_req,
   output logic [2:0] move_op,
   input  logic       move_ack,
   input  logic       move_ok,
   output logic       sched_err
);

   state_e     state_q, state_d;
   move_op_e   op_q, op_d;
   logic [3:0] pend_q, pend_d;
   logic       grav_due;
   logic       grant_grav;
   logic       clr_cnt;

   grav_timer #(
      .MOVE_DELAY (MOVE_DELAY)
   ) u_grav_timer (
      .clk         (vga_clk),
      .rst_n       (i_reset_n),
      .draw_finish (draw_finish),
      .clr_cnt     (clr_cnt),
      .clr_due     (grant_grav),
      .grav_due    (grav_due)
   );

`ifdef MOVE_SCHED_TIMEOUT_EN
   logic [7:0] wd_q, wd_d;
   logic       sched_err_q, sched_err_d;
`endif

   // State register
   always_ff @(posedge vga_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_NONE;
         pend_q      <= 4'd0;
`ifdef MOVE_SCHED_TIMEOUT_EN
         wd_q        <= 8'd0;
         sched_err_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         pend_q      <= pend_d;
`ifdef MOVE_SCHED_TIMEOUT_EN
         wd_q        <= wd_d;
         sched_err_q <= sched_err_d;
`endif
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      pend_d     = pend_q | op_keys;
      grant_grav = 1'b0;
      clr_cnt    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Keys pressed in the grant cycle only set pending; they are
            // eligible from the next frame on.
            if (draw_finish && (grav_due || (pend_q != 4'd0))) begin
               op_d       = pick_op(grav_due, pend_q);
               grant_grav = (op_d == OP_GRAVITY);
               pend_d     = (pend_q & ~op_key_mask(op_d)) | op_keys;
               state_d    = ST_REQ;
            end
         end
         ST_REQ: begin
            if (move_ack) begin
               clr_cnt = (op_q == OP_SOFT_DOWN) && move_ok;
               state_d = ((op_q == OP_GRAVITY) && !move_ok) ? ST_LOCK : ST_IDLE;
            end
         end
         ST_LOCK: begin
            if (move_ack) begin
               state_d = ST_IDLE;
               pend_d  = 4'd0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
`ifdef MOVE_SCHED_TIMEOUT_EN
      sched_err_d = 1'b0;
      if ((state_q != ST_IDLE) && !move_ack && (wd_q == WD_LIMIT)) begin
         state_d     = ST_IDLE;
         sched_err_d = 1'b1;
      end
      // Restart on every state change so LOCK gets its own full window.
      wd_d = ((state_q != ST_IDLE) && (state_d == state_q)) ? wd_q + 8'd1 : 8'd0;
`endif
   end

   // Outputs derive from state so an asynchronous reset drops them at once.
   always_comb begin
      move_req = 1'b0;
      move_op  = OP_NONE;
      case (state_q)
         ST_REQ: begin
            move_req = 1'b1;
            move_op  = op_q;
         end
         ST_LOCK: begin
            move_req = 1'b1;
            move_op  = OP_LOCK;
         end
         default: begin
            move_req = 1'b0;
            move_op  = OP_NONE;
         end
      endcase
   end

`ifdef MOVE_SCHED_TIMEOUT_EN
   assign sched_err = sched_err_q;
`else
   assign sched_err = 1'b0;
`endif

endmodule

// File: tb/tb_move_sched.sv
// tb/tb_move_sched.sv - directed self-checking bench for move_sched (MOVE_DELAY=3)
module tb_move_sched;

   logic       vga_clk = 1'b0;
   logic       i_reset_n;
   logic [3:0] op_keys;
   logic       draw_finish;
   logic       move_req;
   logic [2:0] move_op;
   logic       move_ack;
   logic       move_ok;
   logic       sched_err;

   int n_vec = 0;
   int n_err = 0;

   localparam logic [2:0] NONE = 3'd0, ROT = 3'd1, SDN = 3'd2, LFT = 3'd3,
                          RGT = 3'd4, GRV = 3'd5, LCK = 3'd6;

   move_sched #(.MOVE_DELAY(3)) dut (
      .vga_clk     (vga_clk),
      .i_reset_n   (i_reset_n),
      .op_keys     (op_keys),
      .draw_finish (draw_finish),
      .move_req    (move_req),
      .move_op     (move_op),
      .move_ack    (move_ack),
      .move_ok     (move_ok),
      .sched_err   (sched_err)
   );

   always #20 vga_clk = ~vga_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge vga_clk);
      #1;
   endtask

   task automatic frame();
      draw_finish = 1'b1;
      step();
      draw_finish = 1'b0;
   endtask

   task automatic keys(input logic [3:0] k);
      op_keys = k;
      step();
      op_keys = 4'd0;
   endtask

   task automatic ack(input logic ok);
      move_ack = 1'b1;
      move_ok  = ok;
      step();
      move_ack = 1'b0;
      move_ok  = 1'b0;
   endtask

   // Frame with expected request outcome; expected op NONE means no request.
   task automatic frame_exp(input string tag, input logic [2:0] op);
      frame();
      chk({tag, "_req"}, move_req, (op != NONE));
      chk({tag, "_op"}, move_op, op);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      int n;
      i_reset_n = 1'b0; op_keys = 4'd0; draw_finish = 1'b0;
      move_ack = 1'b0; move_ok = 1'b0;
      step(); step();
      chk("rst_req", move_req, 0);
      chk("rst_op", move_op, NONE);
      chk("rst_err", sched_err, 0);
      i_reset_n = 1'b1;
      step();

      // Gravity on every 3rd frame with immediate successful ack
      frame_exp("g1a", NONE);
      frame_exp("g1b", NONE);
      frame_exp("g1c", GRV);
      ack(1);
      chk("g1_drop", move_req, 0);
      chk("g1_op0", move_op, NONE);
      frame_exp("g2a", NONE);
      frame_exp("g2b", NONE);
      frame_exp("g2c", GRV);
      ack(1);
      // Stray ack in idle
      ack(1);
      chk("idle_ack", move_req, 0);

      // Left and right in one frame: LEFT first, RIGHT next frame
      keys(4'b1100);
      frame_exp("lr1", LFT);
      ack(1);
      frame_exp("lr2", RGT);
      ack(1);

      // Blocked gravity leads to LOCK; pending rotate gets discarded
      frame_exp("blk", GRV);
      keys(4'b0001);
      ack(0);
      chk("lock_req", move_req, 1);
      chk("lock_op", move_op, LCK);
      step();
      chk("lock_hold", move_op, LCK);
      ack(1);
      chk("lock_done", move_req, 0);
      frame_exp("lock_pend", NONE);

      // Three rotate presses collapse to one grant
      keys(4'b0001); keys(4'b0001); keys(4'b0001);
      frame_exp("rot1", ROT);
      ack(1);
      frame_exp("rot_g", GRV);
      ack(1);
      frame_exp("rot_once", NONE);

      // Applied soft drop restarts the frame count
      keys(4'b0010);
      frame_exp("sd", SDN);
      ack(1);
      frame_exp("sd_c1", NONE);
      frame_exp("sd_c2", NONE);
      frame_exp("sd_c3", GRV);
      ack(1);

      // Priority with all keys pending
      keys(4'b1111);
      frame_exp("pr_rot", ROT);
      ack(1);
      frame_exp("pr_lft", LFT);
      ack(1);
      frame_exp("pr_grv", GRV);
      ack(1);
      frame_exp("pr_rgt", RGT);
      ack(1);
      frame_exp("pr_sdn", SDN);
      ack(1);

      // Same-key pulse in grant cycle re-arms the key
      keys(4'b0100);
      op_keys = 4'b0100;
      frame_exp("rearm1", LFT);
      op_keys = 4'd0;
      ack(1);
      frame_exp("rearm2", LFT);
      ack(1);
      frame_exp("rearm_g", GRV);
      ack(1);

      // Withheld ack
      frame_exp("wd_a", NONE);
      frame_exp("wd_b", NONE);
      frame_exp("wd_c", GRV);
      n = 1;
      for (int i = 0; i < 300; i++) begin
         step();
         if (sched_err) break;
         n++;
      end
`ifdef MOVE_SCHED_TIMEOUT_EN
      chk("wd_err", sched_err, 1);
      chk("wd_len", n, 256);
      chk("wd_drop", move_req, 0);
      step();
      chk("wd_pulse", sched_err, 0);
`else
      chk("nowd_req", move_req, 1);
      chk("nowd_err", sched_err, 0);
`endif

      // Reset in the middle of a handshake
      if (!move_req) begin
         keys(4'b0001);
         frame();
      end
      chk("mid_req", move_req, 1);
      #5;
      i_reset_n = 1'b0;
      #1;
      chk("arst_req", move_req, 0);
      chk("arst_op", move_op, NONE);
      chk("arst_err", sched_err, 0);
      step(); step();
      i_reset_n = 1'b1;
      step();
      chk("post_req", move_req, 0);
      frame_exp("replay1", NONE);
      frame_exp("replay2", NONE);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
